if_fetch_stage: RTL

//  Instruction-fetch stage directly upstream of the IF/ID pipeline register.

---
 rtl/if_fetch_stage_pkg.sv | 18 +
 rtl/if_fetch_stage.sv | 108 ++++++++++
 2 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Fetch FSM encoding, reset PC and bubble word.
package if_fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_WAIT = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues single-outstanding
// memory requests and buffers one word for the IF/ID register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        le,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        valid_out
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  fetch_pc_d;
    logic         pend_q;
    logic         pend_d;
    logic [31:0]  ptgt_q;
    logic [31:0]  ptgt_d;
    logic         buf_valid_q;
    logic [31:0]  instr_q;
    logic [31:0]  pc_q;

    logic         consume;
    logic         req;
    logic         ack;
    logic [31:0]  tgt;

    assign consume = le & buf_valid_q;
    assign req     = ~reset & ((state_q == FS_WAIT) | ~buf_valid_q | consume);
    assign ack     = req & imem_ack;
    assign tgt     = word_align(redirect_target);

    assign imem_req        = req;
    assign imem_addr       = fetch_pc_q;
    assign instruction_out = instr_q;
    assign pc_out          = pc_q;
    assign valid_out       = buf_valid_q;

    // A redirect arriving while a request is on the bus is parked so the
    // in-flight address stays stable; the delay-slot word still lands.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_d     = pend_q;
        ptgt_d     = ptgt_q;
        if (ack) begin
            pend_d = 1'b0;
            if (redirect) begin
                fetch_pc_d = tgt;
            end else if (pend_q) begin
                fetch_pc_d = ptgt_q;
            end else begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
        end else if (redirect) begin
            if (req) begin
                pend_d = 1'b1;
                ptgt_d = tgt;
            end else begin
                fetch_pc_d = tgt;
            end
        end
    end

    always_comb begin
        state_d = FS_IDLE;
        if (req && !ack) begin
            state_d = FS_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FS_IDLE;
            fetch_pc_q  <= RESET_PC;
            pend_q      <= 1'b0;
            ptgt_q      <= RESET_PC;
            buf_valid_q <= 1'b0;
            instr_q     <= NOP_WORD;
            pc_q        <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_q     <= pend_d;
            ptgt_q     <= ptgt_d;
            if (ack) begin
                buf_valid_q <= 1'b1;
                instr_q     <= imem_rdata;
                pc_q        <= fetch_pc_q;
            end else if (consume) begin
                buf_valid_q <= 1'b0;
                instr_q     <= NOP_WORD;
            end
        end
    end

endmodule
